// File: rtl/axil_rd_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axil_rd_rr_arbiter
//
// Shares one AXI4-lite read master port among S_COUNT AXI4-lite read slave
// ports. Arbitration is round-robin, and only one transaction is in flight at
// any time. Every handshake output comes straight from a register.
//
// Optional feature (macro AXIL_RD_ARB_TIMEOUT_EN):
//   If the downstream slave does not return R within TIMEOUT cycles of
//   entering DATA, the requester receives SLVERR with zero data. The arbiter
//   then drains exactly one late R beat before it accepts new work.
//
// Ports:
//   clk, rst            clock (posedge) and synchronous active-high reset
//   s_axil_ar*          per-port read address channel (packed, port 0 in LSBs)
//   s_axil_r*           per-port read data channel; rdata/rresp replicated
//   m_axil_ar*          shared read address channel toward the slave
//   m_axil_r*           shared read data channel from the slave
//   busy                high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module axil_rd_rr_arbiter #(
    parameter int S_COUNT    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic [S_COUNT*ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [S_COUNT*3-1:0]          s_axil_arprot,
    input  logic [S_COUNT-1:0]            s_axil_arvalid,
    output logic [S_COUNT-1:0]            s_axil_arready,
    output logic [S_COUNT*DATA_WIDTH-1:0] s_axil_rdata,
    output logic [S_COUNT*2-1:0]          s_axil_rresp,
    output logic [S_COUNT-1:0]            s_axil_rvalid,
    input  logic [S_COUNT-1:0]            s_axil_rready,

    output logic [ADDR_WIDTH-1:0]         m_axil_araddr,
    output logic [2:0]                    m_axil_arprot,
    output logic                          m_axil_arvalid,
    input  logic                          m_axil_arready,
    input  logic [DATA_WIDTH-1:0]         m_axil_rdata,
    input  logic [1:0]                    m_axil_rresp,
    input  logic                          m_axil_rvalid,
    output logic                          m_axil_rready,

    output logic                          busy
);

    localparam int GW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

`ifdef AXIL_RD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_ACCEPT = 6'b000010,
        S_ADDR   = 6'b000100,
        S_DATA   = 6'b001000,
        S_RESP   = 6'b010000,
        S_DRAIN  = 6'b100000
    } state_t;
`else
    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_ACCEPT = 5'b00010,
        S_ADDR   = 5'b00100,
        S_DATA   = 5'b01000,
        S_RESP   = 5'b10000
    } state_t;
`endif

    state_t                  state_r, state_next_s;
    logic [GW-1:0]           grant_r, grant_next_s;
    logic [GW-1:0]           last_grant_r, last_grant_next_s;
    logic [S_COUNT-1:0]      s_arready_r, s_arready_next_s;
    logic [S_COUNT-1:0]      s_rvalid_r, s_rvalid_next_s;
    logic                    m_arvalid_r, m_arvalid_next_s;
    logic                    m_rready_r, m_rready_next_s;
    logic                    busy_r, busy_next_s;
    logic [ADDR_WIDTH-1:0]   araddr_r, araddr_next_s;
    logic [2:0]              arprot_r, arprot_next_s;
    logic [DATA_WIDTH-1:0]   rdata_r, rdata_next_s;
    logic [1:0]              rresp_r, rresp_next_s;
`ifdef AXIL_RD_ARB_TIMEOUT_EN
    logic [CW-1:0]           tmo_cnt_r, tmo_cnt_next_s;
    logic                    timed_out_r, timed_out_next_s;
`endif

    logic                    req_found_s;
    logic [GW-1:0]           req_grant_s;
    logic [ADDR_WIDTH-1:0]   araddr_arr_s [S_COUNT];
    logic [2:0]              arprot_arr_s [S_COUNT];

    // Port index that is 'ofs+1' places above 'base', wrapping at S_COUNT.
    function automatic logic [GW-1:0] rr_index(input logic [GW-1:0] base, input int ofs);
        rr_index = GW'((int'(base) + 1 + ofs) % S_COUNT);
    endfunction

    for (genvar g = 0; g < S_COUNT; g++) begin : g_unpack
        assign araddr_arr_s[g] = s_axil_araddr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign arprot_arr_s[g] = s_axil_arprot[g*3 +: 3];
    end

    // Round-robin pick: first requesting port above last_grant_r, wrapping around.
    always_comb begin
        req_found_s = 1'b0;
        req_grant_s = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (!req_found_s && s_axil_arvalid[rr_index(last_grant_r, i)]) begin
                req_found_s = 1'b1;
                req_grant_s = rr_index(last_grant_r, i);
            end else begin
                req_found_s = req_found_s;
            end
        end
    end

    // Next-state and next-output logic; every register holds its value unless a state changes it.
    always_comb begin
        state_next_s      = state_r;
        grant_next_s      = grant_r;
        last_grant_next_s = last_grant_r;
        s_arready_next_s  = s_arready_r;
        s_rvalid_next_s   = s_rvalid_r;
        m_arvalid_next_s  = m_arvalid_r;
        m_rready_next_s   = m_rready_r;
        araddr_next_s     = araddr_r;
        arprot_next_s     = arprot_r;
        rdata_next_s      = rdata_r;
        rresp_next_s      = rresp_r;
`ifdef AXIL_RD_ARB_TIMEOUT_EN
        tmo_cnt_next_s    = tmo_cnt_r;
        timed_out_next_s  = timed_out_r;
`endif

        case (state_r)
            S_IDLE: begin
                if (req_found_s) begin
                    grant_next_s                  = req_grant_s;
                    s_arready_next_s              = '0;
                    s_arready_next_s[req_grant_s] = 1'b1;
                    state_next_s                  = S_ACCEPT;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_ACCEPT: begin
                // arready is high during this cycle, so the handshake completes at this edge.
                s_arready_next_s = '0;
                araddr_next_s    = araddr_arr_s[grant_r];
                arprot_next_s    = arprot_arr_s[grant_r];
                m_arvalid_next_s = 1'b1;
                state_next_s     = S_ADDR;
            end
            S_ADDR: begin
                if (m_axil_arready) begin
                    m_arvalid_next_s = 1'b0;
                    m_rready_next_s  = 1'b1;
`ifdef AXIL_RD_ARB_TIMEOUT_EN
                    tmo_cnt_next_s   = '0;
`endif
                    state_next_s     = S_DATA;
                end else begin
                    state_next_s = S_ADDR;
                end
            end
            S_DATA: begin
                if (m_axil_rvalid) begin
                    rdata_next_s              = m_axil_rdata;
                    rresp_next_s              = m_axil_rresp;
                    m_rready_next_s           = 1'b0;
                    s_rvalid_next_s           = '0;
                    s_rvalid_next_s[grant_r]  = 1'b1;
`ifdef AXIL_RD_ARB_TIMEOUT_EN
                    timed_out_next_s          = 1'b0;
`endif
                    state_next_s              = S_RESP;
                end
`ifdef AXIL_RD_ARB_TIMEOUT_EN
                else if (tmo_cnt_r == CW'(TIMEOUT - 1)) begin
                    // Slave went silent: answer the requester with SLVERR.
                    rdata_next_s             = '0;
                    rresp_next_s             = 2'b10;
                    m_rready_next_s          = 1'b0;
                    s_rvalid_next_s          = '0;
                    s_rvalid_next_s[grant_r] = 1'b1;
                    timed_out_next_s         = 1'b1;
                    state_next_s             = S_RESP;
                end else begin
                    tmo_cnt_next_s = tmo_cnt_r + CW'(1);
                end
`else
                else begin
                    state_next_s = S_DATA;
                end
`endif
            end
            S_RESP: begin
                if (s_axil_rready[grant_r]) begin
                    s_rvalid_next_s   = '0;
                    last_grant_next_s = grant_r;
`ifdef AXIL_RD_ARB_TIMEOUT_EN
                    if (timed_out_r) begin
                        // A late beat may still arrive; absorb it before new work.
                        m_rready_next_s = 1'b1;
                        state_next_s    = S_DRAIN;
                    end else begin
                        state_next_s = S_IDLE;
                    end
`else
                    state_next_s = S_IDLE;
`endif
                end else begin
                    state_next_s = S_RESP;
                end
            end
`ifdef AXIL_RD_ARB_TIMEOUT_EN
            S_DRAIN: begin
                if (m_axil_rvalid) begin
                    m_rready_next_s  = 1'b0;
                    timed_out_next_s = 1'b0;
                    state_next_s     = S_IDLE;
                end else begin
                    state_next_s = S_DRAIN;
                end
            end
`endif
            default: begin
                // Illegal encoding: fall back to a quiet IDLE.
                s_arready_next_s = '0;
                s_rvalid_next_s  = '0;
                m_arvalid_next_s = 1'b0;
                m_rready_next_s  = 1'b0;
                state_next_s     = S_IDLE;
            end
        endcase

        busy_next_s = (state_next_s != S_IDLE);
    end

    // State and registered outputs; reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            grant_r      <= '0;
            last_grant_r <= GW'(S_COUNT - 1);
            s_arready_r  <= '0;
            s_rvalid_r   <= '0;
            m_arvalid_r  <= 1'b0;
            m_rready_r   <= 1'b0;
            busy_r       <= 1'b0;
            araddr_r     <= '0;
            arprot_r     <= 3'b000;
            rdata_r      <= '0;
            rresp_r      <= 2'b00;
`ifdef AXIL_RD_ARB_TIMEOUT_EN
            tmo_cnt_r    <= '0;
            timed_out_r  <= 1'b0;
`endif
        end else begin
            state_r      <= state_next_s;
            grant_r      <= grant_next_s;
            last_grant_r <= last_grant_next_s;
            s_arready_r  <= s_arready_next_s;
            s_rvalid_r   <= s_rvalid_next_s;
            m_arvalid_r  <= m_arvalid_next_s;
            m_rready_r   <= m_rready_next_s;
            busy_r       <= busy_next_s;
            araddr_r     <= araddr_next_s;
            arprot_r     <= arprot_next_s;
            rdata_r      <= rdata_next_s;
            rresp_r      <= rresp_next_s;
`ifdef AXIL_RD_ARB_TIMEOUT_EN
            tmo_cnt_r    <= tmo_cnt_next_s;
            timed_out_r  <= timed_out_next_s;
`endif
        end
    end

    assign s_axil_arready = s_arready_r;
    assign s_axil_rvalid  = s_rvalid_r;
    assign s_axil_rdata   = {S_COUNT{rdata_r}};
    assign s_axil_rresp   = {S_COUNT{rresp_r}};
    assign m_axil_araddr  = araddr_r;
    assign m_axil_arprot  = arprot_r;
    assign m_axil_arvalid = m_arvalid_r;
    assign m_axil_rready  = m_rready_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_axil_rd_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axil_rd_rr_arbiter
//
// Directed bench for axil_rd_rr_arbiter (S_COUNT=4, 32-bit address/data).
// Inputs are driven on the falling edge and outputs are checked on the falling
// edge. Each transaction is stepped cycle by cycle, so every check also pins
// the latency from one stage to the next.
// -----------------------------------------------------------------------------
module tb_axil_rd_rr_arbiter;

    localparam int S_COUNT = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TO      = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [S_COUNT*AW-1:0]  s_axil_araddr;
    logic [S_COUNT*3-1:0]   s_axil_arprot;
    logic [S_COUNT-1:0]     s_axil_arvalid;
    logic [S_COUNT-1:0]     s_axil_arready;
    logic [S_COUNT*DW-1:0]  s_axil_rdata;
    logic [S_COUNT*2-1:0]   s_axil_rresp;
    logic [S_COUNT-1:0]     s_axil_rvalid;
    logic [S_COUNT-1:0]     s_axil_rready;
    logic [AW-1:0]          m_axil_araddr;
    logic [2:0]             m_axil_arprot;
    logic                   m_axil_arvalid;
    logic                   m_axil_arready;
    logic [DW-1:0]          m_axil_rdata;
    logic [1:0]             m_axil_rresp;
    logic                   m_axil_rvalid;
    logic                   m_axil_rready;
    logic                   busy;

    logic [AW-1:0] addr_tbl [S_COUNT];
    logic [2:0]    prot_tbl [S_COUNT];
    int            pend     [S_COUNT];
    int            errors = 0;
    int            checks = 0;
    int            ar_hs  = 0;

    always #5 clk = ~clk;

    axil_rd_rr_arbiter #(
        .S_COUNT    (S_COUNT),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_arprot  (s_axil_arprot),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready),
        .m_axil_araddr  (m_axil_araddr),
        .m_axil_arprot  (m_axil_arprot),
        .m_axil_arvalid (m_axil_arvalid),
        .m_axil_arready (m_axil_arready),
        .m_axil_rdata   (m_axil_rdata),
        .m_axil_rresp   (m_axil_rresp),
        .m_axil_rvalid  (m_axil_rvalid),
        .m_axil_rready  (m_axil_rready),
        .busy           (busy)
    );

    // Count AR handshakes seen on the master side.
    always @(posedge clk) begin
        if (m_axil_arvalid && m_axil_arready) begin
            ar_hs <= ar_hs + 1;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_req();
        for (int p = 0; p < S_COUNT; p++) begin
            s_axil_arvalid[p]         = (pend[p] != 0);
            s_axil_araddr[p*AW +: AW] = addr_tbl[p];
            s_axil_arprot[p*3 +: 3]   = prot_tbl[p];
        end
    endtask

    // One full transaction, starting from an IDLE cycle with requests pending.
    task automatic txn(input int exp_g, input int ar_stall, input int r_hold,
                       input logic [31:0] rdat, input logic [1:0] rrsp);
        int n;
        int hs0;
        logic [S_COUNT-1:0] one_g;
        one_g = S_COUNT'(1) << exp_g;
        n = 0;
        while (s_axil_arready == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("ar_latency", n, 1);
        if (s_axil_arready == '0) begin
            return;
        end
        check_val("arready_grant", s_axil_arready, one_g);
        check_val("busy_accept", busy, 1);
        hs0 = ar_hs;
        @(negedge clk);
        pend[exp_g]--;
        drive_req();
        check_val("arready_drop", s_axil_arready, 0);
        check_val("m_arvalid", m_axil_arvalid, 1);
        check_val("m_araddr", m_axil_araddr, addr_tbl[exp_g]);
        check_val("m_arprot", m_axil_arprot, prot_tbl[exp_g]);
        m_axil_rdata = rdat;
        m_axil_rresp = rrsp;
        for (int i = 0; i < ar_stall; i++) begin
            m_axil_rvalid = 1'b1;
            @(negedge clk);
            check_val("stall_arvalid", m_axil_arvalid, 1);
            check_val("stall_araddr", m_axil_araddr, addr_tbl[exp_g]);
            check_val("stall_rready", m_axil_rready, 0);
        end
        m_axil_rvalid  = 1'b0;
        m_axil_arready = 1'b1;
        @(negedge clk);
        m_axil_arready = 1'b0;
        check_val("data_arvalid", m_axil_arvalid, 0);
        check_val("data_rready", m_axil_rready, 1);
        check_val("data_svalid", s_axil_rvalid, 0);
        m_axil_rvalid = 1'b1;
        @(negedge clk);
        m_axil_rvalid = 1'b0;
        m_axil_rdata  = ~rdat;
        m_axil_rresp  = ~rrsp;
        check_val("resp_rready", m_axil_rready, 0);
        check_val("resp_rvalid", s_axil_rvalid, one_g);
        check_val("resp_rdata", s_axil_rdata[exp_g*DW +: DW], rdat);
        check_val("resp_rresp", s_axil_rresp[exp_g*2 +: 2], rrsp);
        check_val("resp_rdata_repl", s_axil_rdata[((exp_g+1)%S_COUNT)*DW +: DW], rdat);
        for (int i = 0; i < r_hold; i++) begin
            s_axil_rready = ~one_g;
            @(negedge clk);
            check_val("hold_rvalid", s_axil_rvalid, one_g);
            check_val("hold_rdata", s_axil_rdata[exp_g*DW +: DW], rdat);
        end
        s_axil_rready = '1;
        @(negedge clk);
        s_axil_rready = '0;
        check_val("idle_rvalid", s_axil_rvalid, 0);
        check_val("idle_busy", busy, 0);
        check_val("ar_hs_count", ar_hs - hs0, 1);
    endtask

    initial begin
        int n;
        rst            = 1'b1;
        s_axil_arvalid = '0;
        s_axil_araddr  = '0;
        s_axil_arprot  = '0;
        s_axil_rready  = '0;
        m_axil_arready = 1'b0;
        m_axil_rdata   = 32'h0;
        m_axil_rresp   = 2'b00;
        m_axil_rvalid  = 1'b0;
        for (int p = 0; p < S_COUNT; p++) begin
            addr_tbl[p] = 32'h1000_0000 + 32'(p) * 32'h100;
            prot_tbl[p] = 3'(p + 1);
            pend[p]     = 0;
        end
        addr_tbl[2] = 32'h0000_1040;
        repeat (3) @(negedge clk);

        check_val("rst_arready", s_axil_arready, 0);
        check_val("rst_rvalid", s_axil_rvalid, 0);
        check_val("rst_m_arvalid", m_axil_arvalid, 0);
        check_val("rst_m_rready", m_axil_rready, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_rdata", s_axil_rdata, 0);
        check_val("rst_araddr", m_axil_araddr, 0);

        // Single request on port 2, zero wait states.
        rst = 1'b0;
        pend[2] = 1;
        drive_req();
        txn(2, 0, 0, 32'hDEAD_BEEF, 2'b00);

        // Ports 0 and 1 twice each, last_grant=2 -> 0,1,0,1.
        pend[0] = 2;
        pend[1] = 2;
        drive_req();
        txn(0, 0, 0, 32'h0000_0A00, 2'b00);
        txn(1, 0, 0, 32'h0000_0A01, 2'b00);
        txn(0, 0, 0, 32'h0000_0A02, 2'b00);
        txn(1, 0, 0, 32'h0000_0A03, 2'b00);

        // Ports 0,1,3 after last_grant=1 -> 3,0,1.
        pend[0] = 1;
        pend[1] = 1;
        pend[3] = 1;
        drive_req();
        txn(3, 0, 0, 32'h3333_0003, 2'b00);
        txn(0, 0, 0, 32'h3333_0000, 2'b00);
        txn(1, 0, 0, 32'h3333_0001, 2'b00);

        // AR stall of 5 cycles and R back-pressure of 3 cycles on port 0.
        pend[0] = 1;
        drive_req();
        txn(0, 5, 3, 32'h5A5A_1234, 2'b00);

        // DECERR from the slave must pass through unchanged.
        pend[1] = 1;
        drive_req();
        txn(1, 0, 0, 32'h0BAD_0BAD, 2'b11);

        // Reset while waiting in DATA.
        pend[3] = 1;
        drive_req();
        @(negedge clk);
        check_val("rstt_arready", s_axil_arready, 4'b1000);
        @(negedge clk);
        pend[3] = 0;
        drive_req();
        m_axil_arready = 1'b1;
        @(negedge clk);
        m_axil_arready = 1'b0;
        check_val("rstt_rready", m_axil_rready, 1);
        rst = 1'b1;
        @(negedge clk);
        check_val("rstt_m_rready", m_axil_rready, 0);
        check_val("rstt_m_arvalid", m_axil_arvalid, 0);
        check_val("rstt_arready0", s_axil_arready, 0);
        check_val("rstt_rvalid", s_axil_rvalid, 0);
        check_val("rstt_busy", busy, 0);
        check_val("rstt_rdata", s_axil_rdata[DW-1:0], 0);
        rst = 1'b0;
        pend[0] = 1;
        drive_req();
        txn(0, 0, 0, 32'h0F0F_0F0F, 2'b01);

`ifdef AXIL_RD_ARB_TIMEOUT_EN
        // Slave never answers port 2: SLVERR after TO cycles, then drain a late beat.
        pend[2] = 1;
        drive_req();
        @(negedge clk);
        check_val("to_arready", s_axil_arready, 4'b0100);
        @(negedge clk);
        pend[2] = 0;
        drive_req();
        m_axil_arready = 1'b1;
        @(negedge clk);
        m_axil_arready = 1'b0;
        check_val("to_rready", m_axil_rready, 1);
        n = 0;
        while (s_axil_rvalid == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("to_cycles", n, TO);
        check_val("to_rvalid", s_axil_rvalid, 4'b0100);
        check_val("to_rresp", s_axil_rresp[5:4], 2'b10);
        check_val("to_rdata", s_axil_rdata[2*DW +: DW], 0);
        m_axil_rvalid = 1'b1;
        m_axil_rdata  = 32'h1234_5678;
        m_axil_rresp  = 2'b00;
        check_val("to_resp_rready", m_axil_rready, 0);
        s_axil_rready = '1;
        @(negedge clk);
        s_axil_rready = '0;
        check_val("drain_rready", m_axil_rready, 1);
        check_val("drain_busy", busy, 1);
        check_val("drain_rvalid", s_axil_rvalid, 0);
        @(negedge clk);
        m_axil_rvalid = 1'b0;
        check_val("drain_done_rready", m_axil_rready, 0);
        check_val("drain_done_busy", busy, 0);
        pend[1] = 1;
        drive_req();
        txn(1, 0, 0, 32'hCAFE_F00D, 2'b00);
`else
        n = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so that a stuck design still ends the run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axil_rd_rr_arbiter.md
Name: axil_rd_rr_arbiter

Overview:
Shares one AXI4-lite read master port among S_COUNT requesting AXI4-lite read slave ports.
- Round-robin arbitration; exactly one transaction in flight at a time.
- Sits upstream of the read broadcaster/register slices, so several agents can use one read path.
- All handshake outputs are registered.

Parameters:
S_COUNT, 4, number of requester (slave) ports, 1..16
ADDR_WIDTH, 32, address width in bits
DATA_WIDTH, 32, data width in bits
TIMEOUT, 1024, R-channel timeout in clk cycles (used only with the optional feature), must be ≥2

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous, active-high reset
s_axil_araddr  input  S_COUNT*ADDR_WIDTH  per-port read address
s_axil_arprot  input  S_COUNT*3  per-port protection
s_axil_arvalid  input  S_COUNT  per-port address valid
s_axil_arready  output  S_COUNT  per-port address ready, at most one bit high
s_axil_rdata  output  S_COUNT*DATA_WIDTH  read data, same value replicated to every port
s_axil_rresp  output  S_COUNT*2  read response, replicated to every port
s_axil_rvalid  output  S_COUNT  per-port read valid, at most one bit high
s_axil_rready  input  S_COUNT  per-port read ready
m_axil_araddr  output  ADDR_WIDTH  shared read address
m_axil_arprot  output  3  shared protection
m_axil_arvalid  output  1  shared address valid
m_axil_arready  input  1  shared address ready
m_axil_rdata  input  DATA_WIDTH  shared read data
m_axil_rresp  input  2  shared response
m_axil_rvalid  input  1  shared read valid
m_axil_rready  output  1  shared read ready
busy  output  1  high in every state except IDLE

Behaviour:
Reset values:
- All s_axil_arready, s_axil_rvalid, m_axil_arvalid, m_axil_rready = 0.
- busy = 0.
- rdata/rresp/araddr/arprot registers = 0.
- last_grant = S_COUNT-1, so port 0 has top priority first.
- State = IDLE. Reset mid-transaction drops everything and returns to IDLE; no response is generated for the aborted request.

One-hot FSM, states IDLE, ACCEPT, ADDR, DATA, RESP:
- IDLE: if any arvalid, grant = first set bit searching upward (modulo S_COUNT) from last_grant+1. Register grant; set s_axil_arready[grant]=1 for the next cycle; go to ACCEPT.
- ACCEPT: arready[grant] is high for exactly this cycle. AXI rules guarantee arvalid[grant] is still high. Capture araddr/arprot of grant; m_axil_arvalid=1 next cycle; go to ADDR.
- ADDR: hold m_axil_arvalid/araddr/arprot stable until m_axil_arready. On the handshake, drop arvalid, set m_axil_rready=1 next cycle, go to DATA.
  - m_axil_rvalid arriving in ADDR is not accepted; rready stays 0.
- DATA: rready held 1. On m_axil_rvalid: capture rdata/rresp, drop rready, set s_axil_rvalid[grant]=1 next cycle, go to RESP.
- RESP: hold s_axil_rvalid[grant] and data until s_axil_rready[grant]. On the handshake, clear rvalid, set last_grant=grant, go to IDLE.

Timing and rules:
- Min latency with zero wait states: s arvalid at cycle 0 → s arready cycle 1 → m arvalid cycle 2 → m rready cycle 3 → m rvalid cycle 3 → s rvalid cycle 4.
- Next arbitration happens in the IDLE cycle after RESP.
- Requests that arrive while busy wait. No request is dropped.
- Non-granted arvalid never receives arready.
- rresp is passed through unmodified.
- s_axil_rready on non-granted ports is ignored.
- S_COUNT=1: arbitration degenerates to always grant 0.

Optional Feature:
Macro AXIL_RD_ARB_TIMEOUT_EN.
- Defined: a counter clears on entry to DATA and increments each DATA cycle without m_axil_rvalid.
  - On reaching TIMEOUT-1: respond to the granted port with rresp=2'b10 (SLVERR), rdata=0, via RESP.
  - Then enter DRAIN (rready=1) instead of IDLE, and absorb exactly one late m_axil_rvalid beat before returning to IDLE.
  - The counter is not active in ADDR.
- Undefined: no counter and no DRAIN state; DATA waits indefinitely.

Test Plan:
- Port 2 only, araddr=0x0000_1040, slave returns rdata=0xDEAD_BEEF rresp=0 with zero wait → s_axil_rvalid[2] at cycle 4, rdata 0xDEADBEEF; arready only on bit 2.
- Ports 0 and 1 assert arvalid together, twice in a row → grant order 0,1,0,1. Port 3 then joins with ports 0,1,3 after last_grant=1 → grants 3, then 0.
- Hold m_axil_arready=0 for 5 cycles and s_axil_rready[0]=0 for 3 cycles → araddr/arvalid stable during the stall, rvalid/rdata stable, exactly one transaction seen at master.
- Slave returns rresp=2'b11 → port sees rresp=2'b11 unchanged.
- Assert rst during DATA → next cycle all valids/readies 0, busy=0. A subsequent port-0 request completes normally.
- With AXIL_RD_ARB_TIMEOUT_EN, TIMEOUT=16, slave never answers → port receives rresp=2'b10 rdata=0. A late rvalid is drained, and the following request gets correct data.
